// File: rtl/uart_rx_hold_if.sv
// Serial input and held-word output bundle of the UART receive-and-hold block.
interface uart_rx_hold_if #(
    parameter int DBIT       = 8,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic            rx;
    logic [DBIT-1:0] data_out;
    logic            data_valid;
    logic            rx_word_tick;
    logic            frame_err;
    logic            overflow;
    logic [CW-1:0]   fifo_count;

    modport master (
        output rx,
        input  data_out,
        input  data_valid,
        input  rx_word_tick,
        input  frame_err,
        input  overflow,
        input  fifo_count
    );

    modport slave (
        input  rx,
        output data_out,
        output data_valid,
        output rx_word_tick,
        output frame_err,
        output overflow,
        output fifo_count
    );
endinterface

// File: rtl/uart_rx_hold.sv
// UART receiver with a small word queue and a timed hold stage so slow
// consumers sampling data_out cannot miss a received command.
module uart_rx_hold #(
    parameter int DBIT       = 8,
    parameter int CLK_DIV    = 651,
    parameter int FIFO_DEPTH = 4,
    parameter int HOLD_TIME  = 1000000,
    parameter int RETRIGGER  = 0
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_hold_if.slave bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = $clog2(CLK_DIV);
    localparam int NW = $clog2(DBIT);
    localparam int TW = $clog2(HOLD_TIME + 1);

    localparam logic [DW-1:0] DIV_MAX = DW'(CLK_DIV - 1);
    localparam logic [NW-1:0] N_LAST  = NW'(DBIT - 1);
    localparam logic [TW-1:0] T_LOAD  = TW'(HOLD_TIME - 1);
    localparam logic [CW-1:0] C_FULL  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP
    } rx_state_e;

    typedef enum logic {
        H_EMPTY,
        H_HOLD
    } hold_state_e;

    logic            rx_m_q, rx_s_q;
    logic [DW-1:0]   div_q, div_d;
    logic            tick;

    rx_state_e       rs_q, rs_d;
    logic [3:0]      s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] sh_q, sh_d;
    logic            word_q, word_d;
    logic            ferr_q, ferr_d;

    logic [DBIT-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            full, empty, push_ok, pop;
    logic [DBIT-1:0] head;

    hold_state_e     hs_q, hs_d;
    logic [TW-1:0]   t_q, t_d;
    logic [DBIT-1:0] dout_q, dout_d;
    logic            dv_q, dv_d;

    assign tick  = (div_q == DIV_MAX);
    assign div_d = tick ? '0 : div_q + DW'(1);

    always_comb begin
        rs_d   = rs_q;
        s_d    = s_q;
        n_d    = n_q;
        sh_d   = sh_q;
        word_d = 1'b0;
        ferr_d = 1'b0;
        case (rs_q)
            R_IDLE: begin
                if (!rx_s_q) begin
                    rs_d = R_START;
                    s_d  = '0;
                end
            end
            R_START: begin
                if (tick) begin
                    if (s_q == 4'd7) begin
                        if (!rx_s_q) begin
                            rs_d = R_DATA;
                            s_d  = '0;
                            n_d  = '0;
                        end else begin
                            rs_d = R_IDLE;
                        end
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            R_DATA: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        sh_d = {rx_s_q, sh_q[DBIT-1:1]};
                        s_d  = '0;
                        if (n_q == N_LAST) rs_d = R_STOP;
                        else               n_d  = n_q + NW'(1);
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            R_STOP: begin
                if (tick) begin
                    if (s_q == 4'd15) begin
                        rs_d   = R_IDLE;
                        s_d    = '0;
                        word_d = rx_s_q;
                        ferr_d = !rx_s_q;
                    end else begin
                        s_d = s_q + 4'd1;
                    end
                end
            end
            default: rs_d = R_IDLE;
        endcase
    end

    // A pop in the same cycle frees a slot, so a full queue still accepts.
    assign full    = (cnt_q == C_FULL);
    assign empty   = (cnt_q == '0);
    assign push_ok = word_q && (!full || pop);
    assign ovf_d   = word_q && full && !pop;
    assign head    = mem_q[rd_q];
    assign wr_d    = push_ok ? wr_q + AW'(1) : wr_q;
    assign rd_d    = pop ? rd_q + AW'(1) : rd_q;

    always_comb begin
        cnt_d = cnt_q;
        case ({push_ok, pop})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_comb begin
        hs_d   = hs_q;
        t_d    = t_q;
        dout_d = dout_q;
        dv_d   = dv_q;
        pop    = 1'b0;
        case (hs_q)
            H_EMPTY: begin
                if (!empty) begin
                    pop    = 1'b1;
                    dout_d = head;
                    dv_d   = 1'b1;
                    t_d    = T_LOAD;
                    hs_d   = H_HOLD;
                end
            end
            H_HOLD: begin
                if ((RETRIGGER != 0 || t_q == '0) && !empty) begin
                    pop    = 1'b1;
                    dout_d = head;
                    t_d    = T_LOAD;
                end else if (t_q == '0) begin
                    dout_d = '0;
                    dv_d   = 1'b0;
                    hs_d   = H_EMPTY;
                end else begin
                    t_d = t_q - TW'(1);
                end
            end
            default: hs_d = H_EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= sh_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_m_q <= 1'b1;
            rx_s_q <= 1'b1;
            div_q  <= '0;
            rs_q   <= R_IDLE;
            s_q    <= '0;
            n_q    <= '0;
            sh_q   <= '0;
            word_q <= 1'b0;
            ferr_q <= 1'b0;
            wr_q   <= '0;
            rd_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            hs_q   <= H_EMPTY;
            t_q    <= '0;
            dout_q <= '0;
            dv_q   <= 1'b0;
        end else begin
            rx_m_q <= bus.rx;
            rx_s_q <= rx_m_q;
            div_q  <= div_d;
            rs_q   <= rs_d;
            s_q    <= s_d;
            n_q    <= n_d;
            sh_q   <= sh_d;
            word_q <= word_d;
            ferr_q <= ferr_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            hs_q   <= hs_d;
            t_q    <= t_d;
            dout_q <= dout_d;
            dv_q   <= dv_d;
        end
    end

    assign bus.data_out     = dout_q;
    assign bus.data_valid   = dv_q;
    assign bus.rx_word_tick = word_q;
    assign bus.frame_err    = ferr_q;
    assign bus.overflow     = ovf_q;
    assign bus.fifo_count   = cnt_q;
endmodule
